// File: rtl/thumb_fetch_if.sv
// Fetch-unit bus: ROM address/data, decode-side valid/ready handshake,
// branch redirect and halt status. The fetch unit is the master.
interface thumb_fetch_if #(
    parameter int ADDR_W = 3
) ();
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [15:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halted;

    modport master (
        output rom_addr, instr, instr_pc, instr_valid, halted,
        input  rom_data, instr_ready, redirect, redirect_addr
    );

    modport slave (
        input  rom_addr, instr, instr_pc, instr_valid, halted,
        output rom_data, instr_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/thumb_fetch.sv
// Thumb instruction fetch unit: drives the combinational ROM address,
// captures each returned halfword with its word address into a small
// prefetch FIFO and hands the head to the decoder over valid/ready.
// A single-cycle redirect flushes the FIFO and restarts fetch.
// Optional feature macro: FETCH_HALT_DETECT_EN -- stop fetching after a
// Thumb branch-to-self (16'hE7FE) has been pushed, until redirect or reset.
module thumb_fetch #(
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    thumb_fetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_pc;
    logic              halted_q;

    logic              valid;
    logic              pop;
    logic              push;
    logic              halt_hit;

    // Upper ROM half carries the other Thumb halfword of the word; this
    // unit fetches one halfword per word address, so it is dropped.
    logic              unused_rom_hi;
    assign unused_rom_hi = ^bus.rom_data[31:16];

    assign valid = (count != '0);
    assign pop   = valid & bus.instr_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign push  = !bus.redirect & !halted_q & ((count < CNT_W'(DEPTH)) | pop);

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = push & (bus.rom_data[15:0] == 16'hE7FE);
`else
    assign halt_hit = 1'b0;
`endif

    // Control state: fetch address, FIFO pointers/occupancy, halt flag.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_addr;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                // A branch-to-self parks fetch on its own address.
                if (!halt_hit) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
            end
            if (halt_hit) begin
                halted_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture the fetched halfword with its word address.
    // NOTE: storage has no reset; the occupancy count alone decides what is
    // visible, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: bus.rom_data[15:0], pc: fetch_pc};
        end
    end

    // Head presentation: zero when the FIFO is empty.
    // NOTE: both outputs get a default first so no latch is inferred.
    always_comb begin
        bus.instr    = '0;
        bus.instr_pc = '0;
        if (valid) begin
            bus.instr    = mem[rd_ptr].instr;
            bus.instr_pc = mem[rd_ptr].pc;
        end
    end

    assign bus.instr_valid = valid;
    assign bus.rom_addr    = fetch_pc;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_thumb_fetch.sv
// Self-checking bench for thumb_fetch (ADDR_W=3, DEPTH=2, RESET_PC=0).
// Directed table, hand-written corner sequences and random traffic, all
// compared against a queue-based reference model of the fetch rules.
module tb_thumb_fetch;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2;
    localparam int NWORDS = 1 << ADDR_W;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    thumb_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    thumb_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] rom_lo [NWORDS];
    logic [15:0] rom_hi [NWORDS];
    assign bus.rom_data = {rom_hi[bus.rom_addr], rom_lo[bus.rom_addr]};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched {instr, pc}, a fetch pointer and
    // a halt flag, advanced once per clock edge.
    typedef struct {
        logic [15:0] ins;
        int          pc;
    } ent_t;

    ent_t m_q[$];
    int   m_pc;
    bit   m_halted;

    task automatic model_reset();
        m_q.delete();
        m_pc     = 0;
        m_halted = 1'b0;
    endtask

    task automatic model_check();
        bit v;
        v = (m_q.size() > 0);
        check("valid",    32'(bus.instr_valid), 32'(v));
        check("instr",    32'(bus.instr),       v ? 32'(m_q[0].ins) : 32'd0);
        check("instr_pc", 32'(bus.instr_pc),    v ? 32'(m_q[0].pc)  : 32'd0);
        check("rom_addr", 32'(bus.rom_addr),    32'(m_pc));
        check("halted",   32'(bus.halted),      32'(m_halted));
    endtask

    task automatic model_edge(input bit rdy, input bit rd, input int ra);
        ent_t e;
        if (rd) begin
            m_q.delete();
            m_pc     = ra;
            m_halted = 1'b0;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (!m_halted && m_q.size() < DEPTH) begin
                e.ins = rom_lo[m_pc];
                e.pc  = m_pc;
                m_q.push_back(e);
                if (HALT_EN && e.ins == 16'hE7FE) m_halted = 1'b1;
                else m_pc = (m_pc + 1) % NWORDS;
            end
        end
    endtask

    // One clock cycle: called just after a falling edge.
    task automatic cycle(input bit rdy, input bit rd, input int ra);
        bus.instr_ready   = rdy;
        bus.redirect      = rd;
        bus.redirect_addr = ADDR_W'(ra);
        #1;
        model_check();
        @(posedge clk);
        model_edge(rdy, rd, ra);
        @(negedge clk);
    endtask

    typedef struct {
        bit rdy; bit rd; int ra;
        bit v; int ins; int pc; int addr; bit h;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(bit rdy, bit rd, int ra, bit v, int ins, int pc, int addr, bit h);
        vec_t t;
        t.rdy = rdy; t.rd = rd; t.ra = ra;
        t.v = v; t.ins = ins; t.pc = pc; t.addr = addr; t.h = h;
        return t;
    endfunction

    initial begin
        rom_lo[0] = 16'h2000; rom_lo[1] = 16'h3001; rom_lo[2] = 16'h2864; rom_lo[3] = 16'hD1FC;
        rom_lo[4] = 16'hE7FE; rom_lo[5] = 16'h2000; rom_lo[6] = 16'h0000; rom_lo[7] = 16'h0000;
        for (int i = 0; i < NWORDS; i++) rom_hi[i] = 16'($urandom);

        // Stall from reset, release, redirect to 1 with D1FC@3 at head,
        // then stream past E7FE@4.
        vecs[0]  = mk(0, 0, 0, 0, 0,       0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 'h2000,  0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 1, 'h2000,  0, 2, 0);
        vecs[3]  = mk(0, 0, 0, 1, 'h2000,  0, 2, 0);
        vecs[4]  = mk(0, 0, 0, 1, 'h2000,  0, 2, 0);
        vecs[5]  = mk(1, 0, 0, 1, 'h2000,  0, 2, 0);
        vecs[6]  = mk(1, 0, 0, 1, 'h3001,  1, 3, 0);
        vecs[7]  = mk(1, 0, 0, 1, 'h2864,  2, 4, 0);
        vecs[8]  = mk(1, 1, 1, 1, 'hD1FC,  3, HALT_EN ? 4 : 5, HALT_EN);
        vecs[9]  = mk(1, 0, 0, 0, 0,       0, 1, 0);
        vecs[10] = mk(1, 0, 0, 1, 'h3001,  1, 2, 0);
        vecs[11] = mk(1, 0, 0, 1, 'h2864,  2, 3, 0);
        vecs[12] = mk(1, 0, 0, 1, 'hD1FC,  3, 4, 0);
        vecs[13] = mk(1, 0, 0, 1, 'hE7FE,  4, HALT_EN ? 4 : 5, HALT_EN);
        vecs[14] = HALT_EN ? mk(1, 0, 0, 0, 0, 0, 4, 1)
                           : mk(1, 0, 0, 1, 'h2000, 5, 6, 0);

        bus.instr_ready   = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        model_reset();

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_valid",  32'(bus.instr_valid), 32'd0);
        check("rst_addr",   32'(bus.rom_addr),    32'd0);
        check("rst_instr",  32'(bus.instr),       32'd0);
        check("rst_pc",     32'(bus.instr_pc),    32'd0);
        check("rst_halted", 32'(bus.halted),      32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            bus.instr_ready   = vecs[i].rdy;
            bus.redirect      = vecs[i].rd;
            bus.redirect_addr = ADDR_W'(vecs[i].ra);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].v));
            check($sformatf("vec%0d_instr", i), 32'(bus.instr),       32'(vecs[i].ins));
            check($sformatf("vec%0d_pc", i),    32'(bus.instr_pc),    32'(vecs[i].pc));
            check($sformatf("vec%0d_addr", i),  32'(bus.rom_addr),    32'(vecs[i].addr));
            check($sformatf("vec%0d_halt", i),  32'(bus.halted),      32'(vecs[i].h));
            cycle(vecs[i].rdy, vecs[i].rd, vecs[i].ra);
        end

        // Stream from 6 with ready held: wraps 7 -> 0 (or parks on E7FE).
        cycle(1, 1, 6);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0);
        // Redirect to 0: halt cleared, 2000@0 two cycles later.
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        #1;
        check("redir0_instr", 32'(bus.instr),    32'h2000);
        check("redir0_pc",    32'(bus.instr_pc), 32'd0);
        check("redir0_halt",  32'(bus.halted),   32'd0);
        @(negedge clk);
        model_edge(1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);

        // Fill the FIFO, then pulse reset mid-cycle.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        check("full_valid", 32'(bus.instr_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_addr",  32'(bus.rom_addr),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1, 0, 0);
        #1;
        check("refetch_instr", 32'(bus.instr),    32'h2000);
        check("refetch_pc",    32'(bus.instr_pc), 32'd0);
        @(negedge clk);
        model_edge(1, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 12) == 0, int'($urandom % NWORDS));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/thumb_fetch.md
# thumb_fetch

Instruction fetch unit for the FPGA ARM core: drives the word address of the combinational program ROM, captures the returned Thumb halfword into a small prefetch FIFO, and presents instructions to the decode stage over a valid/ready handshake. Supports a one-cycle branch redirect that flushes all prefetched entries. Sits between the program ROM and the decoder.

## Interface
- ADDR_W, 3, ROM word-address width; PC space wraps modulo 2^ADDR_W
- DEPTH, 2, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, fetch address loaded at reset
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- rom_addr  output  ADDR_W  word address to ROM; equals fetch_pc register
- rom_data  input  32  ROM read data, valid combinationally in the same cycle; bits [31:16] ignored
- instr  output  16  instruction at FIFO head; 0 when empty
- instr_pc  output  ADDR_W  word address of instr; 0 when empty
- instr_valid  output  1  FIFO non-empty
- instr_ready  input  1  decoder accepts head this cycle
- redirect  input  1  branch taken; single-cycle pulse
- redirect_addr  input  ADDR_W  new fetch address, sampled when redirect=1
- halted  output  1  fetch stopped on self-branch (see Configuration)

## Operation
- Clock is clk; reset is rst, asynchronous and active-high.
- State: fetch_pc, FIFO storage {instr, pc} × DEPTH, read/write pointers, occupancy count (0..DEPTH), halted flag.
- pop = instr_valid & instr_ready.
- push = !redirect & !halted & (count < DEPTH | pop).
- On push: write {rom_data[15:0], fetch_pc} at write pointer; fetch_pc <= fetch_pc + 1, wrapping from 2^ADDR_W−1 to 0.
- Simultaneous push and pop on a full FIFO: both occur, count unchanged.
- Pop on empty impossible (instr_valid=0); instr_ready ignored when empty.
- Redirect (highest priority): FIFO flushed (count=0, pointers reset), fetch_pc <= redirect_addr, no push that cycle. A pop asserted in the same cycle is a completed transfer; its entry is discarded by the flush. Redirect clears halted.
- Pointers wrap modulo DEPTH; count arithmetic is ADDR-independent, width clog2(DEPTH)+1.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries lost.

## Timing
- Reset values: rom_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0.
- First edge after rst deasserts: push ROM[RESET_PC]; instr_valid=1 after that edge.
- Redirect in cycle N: rom_addr=redirect_addr in cycle N+1, push at end of N+1, instr_valid=1 with instr_pc=redirect_addr in N+2 (two-cycle branch penalty).
- Decoder holding instr_ready=1 continuously: one instruction per cycle, no bubbles.
- Decoder holding instr_ready=0: FIFO fills to DEPTH after DEPTH edges, rom_addr then holds.
- instr/instr_pc are registered FIFO contents; no combinational path from rom_data to outputs.

## Configuration
- FETCH_HALT_DETECT_EN defined: when a pushed word has rom_data[15:0]=16'hE7FE (Thumb branch-to-self), halted <= 1 at that edge; fetch_pc does not advance past that address; no further pushes until redirect or reset. The E7FE entry itself is still delivered once. halted stays 1 until redirect or rst.
- Undefined: no detection; halted tied to 0; E7FE fetched repeatedly in the sequential stream like any other word.

## Test plan
Bench ROM image, words 0..7: 2000, 3001, 2864, D1FC, E7FE, 2000, 0000, 0000 (upper halves random).
- Reset release, instr_ready=1 always -> instr sequence 2000@0, 3001@1, 2864@2, D1FC@3, E7FE@4, one per cycle, first valid one edge after reset release.
- instr_ready=0 for 5 cycles -> count reaches DEPTH, rom_addr holds at DEPTH, instr stays 2000@0; release -> 3001@1 follows with no gap.
- Redirect to 1 while D1FC@3 at head with instr_ready=1 -> flush; two cycles later instr=3001, instr_pc=1.
- Macro undefined, run 10 cycles ready=1 -> pc sequence wraps 7 -> 0, instr returns to 2000@0; halted stays 0.
- FETCH_HALT_DETECT_EN defined -> after E7FE@4 pushed, halted=1, rom_addr held at 4, E7FE delivered once then instr_valid=0; redirect to 0 -> halted=0, 2000@0 two cycles later.
- Assert rst for one cycle mid-stream with FIFO full -> instr_valid=0, rom_addr=0 immediately; refetch starts at 2000@0.
